// File: rtl/pht_port_sched.sv
// pht_port_sched
//   Schedules the single-port PHT SRAM of the branch predictor. ID-stage lookups
//   and MM-stage counter updates share one port. Updates are queued and applied
//   as read-modify-write operations on 2-bit saturating counters. After reset,
//   every entry is written with INIT_CTR before any traffic is accepted.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   lk_valid/lk_index/lk_ready  lookup request handshake
//   lk_rvalid/lk_taken          lookup result, one cycle after acceptance
//   up_valid/up_index/up_taken  update request (enqueued when up_ready)
//   up_ready                    update queue can accept
//   ram_en/ram_we/ram_addr      SRAM strobe, write enable, address
//   ram_wdata/ram_rdata         SRAM write data, read data (one cycle latency)
//   clear_done                  table initialisation finished
//
// Optional build macro PHT_SCHED_PERF_EN adds 32-bit counters
//   cnt_lk_stall, cnt_up_stall, cnt_rmw_done.

module pht_port_sched #(
    parameter int         IDX_W    = 10,
    parameter int         Q_DEPTH  = 4,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_index,
    output logic             lk_ready,
    output logic             lk_rvalid,
    output logic             lk_taken,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_index,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             ram_en,
    output logic             ram_we,
    output logic [IDX_W-1:0] ram_addr,
    output logic [1:0]       ram_wdata,
    input  logic [1:0]       ram_rdata,
`ifdef PHT_SCHED_PERF_EN
    output logic [31:0]      cnt_lk_stall,
    output logic [31:0]      cnt_up_stall,
    output logic [31:0]      cnt_rmw_done,
`endif
    output logic             clear_done
);

    localparam int PTR_W = $clog2(Q_DEPTH);

    typedef enum logic       {S_CLEAR, S_RUN}      main_state_t;
    typedef enum logic [1:0] {U_IDLE, U_RD, U_WR}  upd_state_t;

    main_state_t      r_state, w_state_nxt;
    upd_state_t       r_ustate, w_ustate_nxt;

    logic [IDX_W-1:0] r_clear_ptr;
    logic             r_clear_done;
    logic             r_lk_rvalid;

    logic [IDX_W-1:0] r_q_idx   [Q_DEPTH];
    logic             r_q_taken [Q_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [1:0]       r_ctr;
    logic             r_ctr_first;

    logic             w_run, w_full, w_lk_acc, w_enq, w_deq, w_eng_grant;
    logic [1:0]       w_ctr, w_ctr_new;

    // Outputs are forced quiet while reset is asserted so no SRAM write can
    // land in the reset cycle (an in-flight RMW is simply dropped).
    assign w_run       = (r_state == S_RUN) && !reset;
    assign w_full      = (r_count == (PTR_W+1)'(Q_DEPTH));
    assign w_lk_acc    = lk_valid && lk_ready;
    assign w_enq       = up_valid && up_ready;
    assign w_eng_grant = w_run && !w_lk_acc;

    assign lk_ready   = w_run && !w_full;
    assign up_ready   = w_run && !w_full;
    assign lk_rvalid  = r_lk_rvalid && !reset;
    assign lk_taken   = lk_rvalid && ram_rdata[1];
    assign clear_done = r_clear_done && !reset;

    // The counter is only on ram_rdata in the first U_WR cycle; later cycles
    // (while lookups hold the port) use the captured copy.
    assign w_ctr = r_ctr_first ? ram_rdata : r_ctr;

    always_comb begin
        w_ctr_new = w_ctr;
        if (r_q_taken[r_rd_ptr]) begin
            if (w_ctr != 2'd3) w_ctr_new = w_ctr + 2'd1;
        end else begin
            if (w_ctr != 2'd0) w_ctr_new = w_ctr - 2'd1;
        end
    end

    // Main FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clear_ptr == '1) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_clear_ptr  <= '0;
            r_clear_done <= 1'b0;
            r_lk_rvalid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lk_rvalid <= w_lk_acc;
            if (r_state == S_CLEAR) begin
                r_clear_ptr <= r_clear_ptr + 1'b1;
                if (r_clear_ptr == '1) r_clear_done <= 1'b1;
            end
        end
    end

    // Update engine FSM
    always_comb begin
        w_ustate_nxt = r_ustate;
        w_deq        = 1'b0;
        case (r_ustate)
            U_IDLE: if (r_count != '0) w_ustate_nxt = U_RD;
            U_RD:   if (w_eng_grant) w_ustate_nxt = U_WR;
            U_WR: begin
                if (w_eng_grant) begin
                    w_deq        = 1'b1;
                    w_ustate_nxt = U_IDLE;
                end
            end
            default: w_ustate_nxt = U_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ustate    <= U_IDLE;
            r_ctr       <= '0;
            r_ctr_first <= 1'b0;
        end else begin
            r_ustate    <= w_ustate_nxt;
            r_ctr_first <= (r_ustate == U_RD) && w_eng_grant;
            if (r_ustate == U_WR) r_ctr <= w_ctr;
        end
    end

    // SRAM port mux: clear walk, then lookup, then update engine
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_clear_ptr;
                ram_wdata = INIT_CTR;
            end else if (w_lk_acc) begin
                ram_en   = 1'b1;
                ram_addr = lk_index;
            end else if (r_ustate == U_RD) begin
                ram_en   = 1'b1;
                ram_addr = r_q_idx[r_rd_ptr];
            end else if (r_ustate == U_WR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_q_idx[r_rd_ptr];
                ram_wdata = w_ctr_new;
            end
        end
    end

    // Update queue
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_wr_ptr]   <= up_index;
            r_q_taken[r_wr_ptr] <= up_taken;
        end
    end

`ifdef PHT_SCHED_PERF_EN
    logic [31:0] r_cnt_lk_stall, r_cnt_up_stall, r_cnt_rmw_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_lk_stall <= '0;
            r_cnt_up_stall <= '0;
            r_cnt_rmw_done <= '0;
        end else begin
            if (w_run && lk_valid && !lk_ready) r_cnt_lk_stall <= r_cnt_lk_stall + 32'd1;
            if (w_run && up_valid && !up_ready) r_cnt_up_stall <= r_cnt_up_stall + 32'd1;
            if (w_deq)                          r_cnt_rmw_done <= r_cnt_rmw_done + 32'd1;
        end
    end

    assign cnt_lk_stall = r_cnt_lk_stall;
    assign cnt_up_stall = r_cnt_up_stall;
    assign cnt_rmw_done = r_cnt_rmw_done;
`endif

endmodule

// File: tb/tb_pht_port_sched.sv
// Testbench for pht_port_sched: SRAM model, queue-based reference model with a
// per-cycle compare process, directed scenarios with literal expectations and
// randomized traffic (including occasional resets).

module tb_pht_port_sched;

    localparam int         IDX_W   = 4;
    localparam int         Q_DEPTH = 4;
    localparam int         N       = 16;
    localparam logic [1:0] INIT    = 2'b01;

    logic             clk = 1'b0;
    logic             reset;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_index;
    logic             lk_ready, lk_rvalid, lk_taken;
    logic             up_valid;
    logic [IDX_W-1:0] up_index;
    logic             up_taken;
    logic             up_ready;
    logic             ram_en, ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [1:0]       ram_wdata;
    logic [1:0]       ram_rdata = 2'b00;
    logic             clear_done;

    pht_port_sched #(
        .IDX_W    (IDX_W),
        .Q_DEPTH  (Q_DEPTH),
        .INIT_CTR (INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lk_valid   (lk_valid),
        .lk_index   (lk_index),
        .lk_ready   (lk_ready),
        .lk_rvalid  (lk_rvalid),
        .lk_taken   (lk_taken),
        .up_valid   (up_valid),
        .up_index   (up_index),
        .up_taken   (up_taken),
        .up_ready   (up_ready),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    // SRAM model plus a log of writes for directed literal checks
    logic [1:0] mem [N];
    int         wlog_a[$];
    int         wlog_d[$];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wlog_a.push_back(int'(ram_addr));
                wlog_d.push_back(int'(ram_wdata));
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic tk);
        int v;
        v = int'(c) + (tk ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    // Reference model
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             tk;
    } upd_t;

    upd_t       m_q[$];
    int         m_clear = 0;
    bit         m_run   = 0;
    bit         m_done  = 0;
    bit         m_rv    = 0;
    bit         m_rv_tk = 0;
    int         m_eng   = 0;   // 0 waiting, 1 read pending, 2 write pending
    logic [1:0] ref_pht [N];

    always @(negedge clk) begin
        bit         full, lk_acc, grant, e_en, e_we;
        int         e_addr, e_wd;
        upd_t       u;
        if (reset) begin
            chk("rst_lk_ready", int'(lk_ready), 0);
            chk("rst_up_ready", int'(up_ready), 0);
            chk("rst_lk_rvalid", int'(lk_rvalid), 0);
            chk("rst_lk_taken", int'(lk_taken), 0);
            chk("rst_ram_en", int'(ram_en), 0);
            chk("rst_ram_we", int'(ram_we), 0);
            chk("rst_ram_addr", int'(ram_addr), 0);
            chk("rst_ram_wdata", int'(ram_wdata), 0);
            chk("rst_clear_done", int'(clear_done), 0);
            m_q.delete();
            m_clear = 0; m_run = 0; m_done = 0; m_rv = 0; m_eng = 0;
        end else begin
            full   = (m_q.size() == Q_DEPTH);
            lk_acc = m_run && lk_valid && !full;
            grant  = m_run && !lk_acc;
            e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
            if (!m_run) begin
                e_en = 1; e_we = 1; e_addr = m_clear; e_wd = int'(INIT);
            end else if (lk_acc) begin
                e_en = 1; e_addr = int'(lk_index);
            end else if (m_eng == 1) begin
                e_en = 1; e_addr = int'(m_q[0].idx);
            end else if (m_eng == 2) begin
                e_en = 1; e_we = 1; e_addr = int'(m_q[0].idx);
                e_wd = int'(sat(ref_pht[m_q[0].idx], m_q[0].tk));
            end
            chk("lk_ready", int'(lk_ready), int'(m_run && !full));
            chk("up_ready", int'(up_ready), int'(m_run && !full));
            chk("lk_rvalid", int'(lk_rvalid), int'(m_rv));
            chk("lk_taken", int'(lk_taken), int'(m_rv && m_rv_tk));
            chk("clear_done", int'(clear_done), int'(m_done));
            chk("ram_en", int'(ram_en), int'(e_en));
            if (e_en) begin
                chk("ram_we", int'(ram_we), int'(e_we));
                chk("ram_addr", int'(ram_addr), e_addr);
                if (e_we) chk("ram_wdata", int'(ram_wdata), e_wd);
            end
            // advance model by one cycle
            if (!m_run) begin
                ref_pht[m_clear] = INIT;
                m_clear++;
                m_rv = 0;
                if (m_clear == N) begin
                    m_run = 1;
                    m_done = 1;
                end
            end else begin
                m_rv = lk_acc;
                if (lk_acc) m_rv_tk = ref_pht[lk_index][1];
                case (m_eng)
                    0: if (m_q.size() != 0) m_eng = 1;
                    1: if (grant) m_eng = 2;
                    default: if (grant) begin
                        u = m_q.pop_front();
                        ref_pht[u.idx] = sat(ref_pht[u.idx], u.tk);
                        m_eng = 0;
                    end
                endcase
                if (up_valid && !full) begin
                    u.idx = up_index;
                    u.tk  = up_taken;
                    m_q.push_back(u);
                end
            end
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lk_valid = 0; lk_index = '0; up_valid = 0; up_index = '0; up_taken = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle_inputs();
        end
    endtask

    // Counts cycles (from the cycle after reset deasserts) until clear_done
    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({nm, "_first_addr"}, int'(ram_addr), 0);
                chk({nm, "_first_we"}, int'(ram_we), 1);
            end
            if (n == 16) chk({nm, "_last_addr"}, int'(ram_addr), 15);
            if (clear_done || n > 100) break;
        end
        chk({nm, "_latency"}, n, 17);
    endtask

    task automatic lookup(input int idx, input int exp_tk, input string nm);
        tick();
        idle_inputs();
        lk_valid = 1; lk_index = idx[IDX_W-1:0];
        @(negedge clk);
        chk({nm, "_addr"}, int'(ram_addr), idx);
        tick();
        idle_inputs();
        @(negedge clk);
        chk({nm, "_rvalid"}, int'(lk_rvalid), 1);
        chk({nm, "_taken"}, int'(lk_taken), exp_tk);
    endtask

    task automatic enqueue(input int idx, input bit tk);
        tick();
        idle_inputs();
        up_valid = 1; up_index = idx[IDX_W-1:0]; up_taken = tk;
    endtask

    initial begin
        int rdy[7];
        int exp_rdy[7];
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
        wait_clear("clear");

        // Lookup of a freshly cleared entry
        lookup(5, 0, "lk5_init");

        // Two taken updates: 01 -> 10 -> 11, then saturate
        wlog_a.delete(); wlog_d.delete();
        enqueue(5, 1);
        enqueue(5, 1);
        idle_cycles(12);
        chk("upd5_nwrites", wlog_a.size(), 2);
        if (wlog_a.size() >= 2) begin
            chk("upd5_w0", wlog_d[0], 2);
            chk("upd5_w1", wlog_d[1], 3);
        end
        lookup(5, 1, "lk5_taken");
        wlog_a.delete(); wlog_d.delete();
        enqueue(5, 1);
        idle_cycles(8);
        chk("upd5_sat_n", wlog_a.size(), 1);
        if (wlog_a.size() >= 1) chk("upd5_sat", wlog_d[0], 3);

        // Not-taken down to 0 and held there
        wlog_a.delete(); wlog_d.delete();
        enqueue(7, 0);
        enqueue(7, 0);
        idle_cycles(12);
        chk("upd7_nwrites", wlog_a.size(), 2);
        if (wlog_a.size() >= 2) begin
            chk("upd7_w0", wlog_d[0], 0);
            chk("upd7_w1", wlog_d[1], 0);
        end
        lookup(7, 0, "lk7_zero");

        // Full queue blocks lookups until the first RMW write pops
        exp_rdy = '{1, 1, 1, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            tick();
            lk_valid = 1; lk_index = 4'd3;
            up_valid = 1; up_index = 4'(i % 4); up_taken = 1;
            @(negedge clk);
            rdy[i] = int'(lk_ready);
            if (i == 5) chk("full_rmw_write", int'(ram_we), 1);
        end
        for (int i = 0; i < 7; i++) chk($sformatf("full_lk_ready%0d", i), rdy[i], exp_rdy[i]);
        idle_cycles(30);

        // Reset during U_WR with three entries queued
        enqueue(9, 1);
        enqueue(9, 1);
        enqueue(9, 1);
        tick();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        chk("rst_wr_no_write", int'(ram_en), 0);
        tick();
        reset = 0;
        wait_clear("reclear");
        idle_cycles(4);
        chk("reclear_mem9", int'(mem[9]), 1);

        // Randomized traffic with varying density and occasional reset
        for (int ph = 0; ph < 4; ph++) begin
            int plk, pup;
            plk = (ph == 0) ? 20 : (ph == 1) ? 90 : (ph == 2) ? 50 : 70;
            pup = (ph == 0) ? 60 : (ph == 1) ? 80 : (ph == 2) ? 30 : 60;
            for (int c = 0; c < 700; c++) begin
                tick();
                lk_valid = ($urandom_range(99) < plk);
                lk_index = IDX_W'($urandom_range(N - 1));
                up_valid = ($urandom_range(99) < pup);
                up_index = IDX_W'($urandom_range(N - 1));
                up_taken = $urandom_range(1);
                reset    = (ph == 3) && ($urandom_range(299) == 0);
            end
        end
        tick();
        reset = 0;
        idle_inputs();
        idle_cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
